// File: rtl/display_jogador_n.sv
// Registered seven-segment driver showing the current player, with a free-running
// blink generator used by the win and tie modes.
module display_jogador_n #(
    parameter int unsigned WIDTH_J      = 2,
    parameter int unsigned N_JOG        = 2,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic [WIDTH_J-1:0] jogador,
    input  logic [1:0]         modo,
    output logic [6:0]         display,
    output logic               pisca_ativo
);

    localparam int unsigned CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_CYCLES - 1);

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    localparam logic [1:0] MODO_VEZ     = 2'b00;
    localparam logic [1:0] MODO_VITORIA = 2'b01;
    localparam logic [1:0] MODO_EMPATE  = 2'b10;

    logic [WIDTH_J-1:0] jog_r;
    logic [1:0]         modo_r;
    logic [CW-1:0]      cnt;
    logic               fase;

    logic [6:0]  digito;
    logic [6:0]  display_next;
    int unsigned jog_n;

    always_comb begin
        jog_n  = 32'(jog_r);
        digito = DASH;
        // Out-of-range players fall back to the dash.
        if (jog_n >= 1 && jog_n <= N_JOG) begin
            case (jog_n)
                1:       digito = 7'b1111001;
                2:       digito = 7'b0100100;
                3:       digito = 7'b0110000;
                4:       digito = 7'b0011001;
                5:       digito = 7'b0010010;
                6:       digito = 7'b0000010;
                7:       digito = 7'b1111000;
                8:       digito = 7'b0000000;
                9:       digito = 7'b0010000;
                default: digito = DASH;
            endcase
        end
    end

    always_comb begin
        display_next = BLANK;
        unique case (modo_r)
            MODO_VEZ:     display_next = digito;
            MODO_VITORIA: display_next = fase ? digito : BLANK;
            MODO_EMPATE:  display_next = fase ? DASH : BLANK;
            default:      display_next = BLANK;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            jog_r       <= '0;
            modo_r      <= MODO_VEZ;
            cnt         <= '0;
            fase        <= 1'b1;
            display     <= DASH;
            pisca_ativo <= 1'b0;
        end else begin
            // Output is computed from the registers as they stood before this edge,
            // so a load shows up exactly one cycle later and never half-applied.
            display     <= display_next;
            pisca_ativo <= (modo_r == MODO_VITORIA) || (modo_r == MODO_EMPATE);
            if (carrega) begin
                jog_r  <= jogador;
                modo_r <= modo;
                cnt    <= '0;
                fase   <= 1'b1;
            end else if (cnt == CNT_MAX) begin
                cnt  <= '0;
                fase <= ~fase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_jogador_n.sv
// Bench for display_jogador_n: three parameterisations checked every cycle against a
// phase-arithmetic model, plus directed spot checks with literal segment patterns.
module tb_display_jogador_n;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset;
    logic       carrega;
    logic [1:0] modo;
    logic [1:0] jog0;
    logic [3:0] jog1;
    logic [6:0] dd [3];
    logic       pp [3];

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] codes [10];
    int bl [3];
    int nj [3];
    int mj [3];
    int mm [3];
    int ms [3];
    logic [6:0] md [3];
    logic       mp [3];

    always #5 clock = ~clock;

    display_jogador_n #(.WIDTH_J(2), .N_JOG(2), .BLINK_CYCLES(4)) dut0 (
        .clock(clock), .reset(reset), .carrega(carrega), .jogador(jog0), .modo(modo),
        .display(dd[0]), .pisca_ativo(pp[0])
    );
    display_jogador_n #(.WIDTH_J(4), .N_JOG(9), .BLINK_CYCLES(3)) dut1 (
        .clock(clock), .reset(reset), .carrega(carrega), .jogador(jog1), .modo(modo),
        .display(dd[1]), .pisca_ativo(pp[1])
    );
    display_jogador_n #(.WIDTH_J(2), .N_JOG(3), .BLINK_CYCLES(1)) dut2 (
        .clock(clock), .reset(reset), .carrega(carrega), .jogador(jog0), .modo(modo),
        .display(dd[2]), .pisca_ativo(pp[2])
    );

    function automatic logic [6:0] digit(int j, int n);
        if (j < 1 || j > n) return DASH;
        return codes[j];
    endfunction

    task automatic check(string tag, logic [6:0] obs, logic [6:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            automatic int  jin = (k == 1) ? int'(jog1) : int'(jog0);
            automatic bit  lit = ((ms[k] / bl[k]) % 2) == 0;
            if (!reset) begin
                mj[k] = 0; mm[k] = 0; ms[k] = 0; md[k] = DASH; mp[k] = 1'b0;
            end else begin
                case (mm[k])
                    0:       md[k] = digit(mj[k], nj[k]);
                    1:       md[k] = lit ? digit(mj[k], nj[k]) : BLANK;
                    2:       md[k] = lit ? DASH : BLANK;
                    default: md[k] = BLANK;
                endcase
                mp[k] = (mm[k] == 1) || (mm[k] == 2);
                if (carrega) begin
                    mj[k] = jin; mm[k] = int'(modo); ms[k] = 0;
                end else begin
                    ms[k]++;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_display%0d", k), dd[k], md[k]);
            check($sformatf("model_pisca%0d", k), {6'b0, pp[k]}, {6'b0, mp[k]});
        end
    endtask

    task automatic load(logic [1:0] j, logic [1:0] m);
        carrega = 1'b1; jog0 = j; jog1 = {2'b00, j}; modo = m;
        tick();
        // Scramble the ports afterwards: they must have no effect between loads.
        carrega = 1'b0; jog0 = 2'($urandom); jog1 = 4'($urandom); modo = 2'($urandom);
    endtask

    initial begin
        codes = '{DASH, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        bl = '{4, 3, 1};
        nj = '{2, 9, 3};
        reset = 1'b0; carrega = 1'b0; modo = 2'b00; jog0 = 2'd0; jog1 = 4'd0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("rst_display", dd[0], DASH);
        check("rst_pisca", {6'b0, pp[0]}, 7'd0);
        repeat (5) tick();
        check("idle_display", dd[0], DASH);

        // Turn mode, players 1 and 2
        load(2'd1, 2'b00);
        tick();
        check("turn_j1", dd[0], 7'b1111001);
        repeat (50) tick();
        check("turn_j1_steady", dd[0], 7'b1111001);
        load(2'd2, 2'b00);
        tick();
        check("turn_j2", dd[0], 7'b0100100);
        repeat (50) tick();

        // Win blink with period 4
        load(2'd2, 2'b01);
        tick();
        check("win_lit_first", dd[0], 7'b0100100);
        check("win_pisca", {6'b0, pp[0]}, 7'd1);
        repeat (3) tick();
        check("win_lit_last", dd[0], 7'b0100100);
        tick();
        check("win_blank_first", dd[0], BLANK);
        repeat (3) tick();
        check("win_blank_last", dd[0], BLANK);
        tick();
        check("win_lit_again", dd[0], 7'b0100100);

        // Tie blink, reloaded mid-sequence restarts the lit phase
        load(2'd1, 2'b10);
        repeat (5) tick();
        check("tie_blank", dd[0], BLANK);
        load(2'd1, 2'b10);
        tick();
        check("tie_reload_lit", dd[0], DASH);
        repeat (3) tick();
        check("tie_reload_lit4", dd[0], DASH);
        tick();
        check("tie_reload_blank", dd[0], BLANK);
        load(2'd2, 2'b11);
        tick();
        check("off_display", dd[0], BLANK);
        check("off_pisca", {6'b0, pp[0]}, 7'd0);

        // Out-of-range players
        load(2'd0, 2'b00);
        tick();
        check("j0_dash", dd[0], DASH);
        load(2'd3, 2'b00);
        tick();
        check("j3_over_n2", dd[0], DASH);
        check("j3_n3", dd[2], 7'b0110000);

        // Reset with a coincident load in the middle of a win blink
        load(2'd1, 2'b01);
        repeat (6) tick();
        reset = 1'b0; carrega = 1'b1; jog0 = 2'd2; jog1 = 4'd2; modo = 2'b01;
        tick();
        check("rst_over_load_display", dd[0], DASH);
        check("rst_over_load_pisca", {6'b0, pp[0]}, 7'd0);
        reset = 1'b1; carrega = 1'b0;
        tick();
        check("after_rst_display", dd[0], DASH);

        // Randomised traffic
        repeat (600) begin
            reset   = ($urandom_range(0, 49) != 0);
            carrega = ($urandom_range(0, 5) == 0);
            jog0    = 2'($urandom);
            jog1    = 4'($urandom);
            modo    = 2'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
